// File: rtl/mult_nmbit.sv
// =============================================================================
// Module   : mult_nmbit
// Brief    : Signed N x M Baugh-Wooley array multiplier with registered product.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mult_nmbit_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module mult_nmbit_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module mult_nmbit #(
    parameter int N = 4,
    parameter int M = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     A,
    input  logic [M-1:0]     B,
    output logic [N+M-1:0]   Prod,
    output logic             out_valid
);
    localparam int c_W = N + M;
    // Sign-term correction 2^(N-1) + 2^(M-1) + 2^(N+M-1); the adds merge when N == M.
    localparam logic [c_W-1:0] c_CORR = c_W'((64'd1 << (N-1)) + (64'd1 << (M-1))
                                             + (64'd1 << (c_W-1)));

    logic [M-1:0][c_W-1:0] w_pp;
    logic [M:0][c_W-1:0]   w_acc;
    logic [c_W-1:0]        r_prod;
    logic                  r_valid;

    // Partial-product rows, row j aligned at bit j; sign row/column inverted.
    for (genvar j = 0; j < M; j++) begin : g_pp_row
        for (genvar k = 0; k < c_W; k++) begin : g_pp_bit
            if ((k - j) < 0 || (k - j) > N-1) begin : g_zero
                assign w_pp[j][k] = 1'b0;
            end else if ((k - j) == N-1 && j == M-1) begin : g_corner
                assign w_pp[j][k] = A[N-1] & B[M-1];
            end else if ((k - j) == N-1 || j == M-1) begin : g_inv
                assign w_pp[j][k] = ~(A[k-j] & B[j]);
            end else begin : g_plain
                assign w_pp[j][k] = A[k-j] & B[j];
            end
        end
    end

    assign w_acc[0] = c_CORR;

    // One ripple-carry adder per row; the carry out of the top bit is dropped (mod 2^W).
    for (genvar j = 0; j < M; j++) begin : g_add_row
        logic [c_W-2:0] w_c;

        mult_nmbit_ha u_ha (
            .a (w_acc[j][0]),
            .b (w_pp[j][0]),
            .s (w_acc[j+1][0]),
            .c (w_c[0])
        );

        for (genvar k = 1; k < c_W-1; k++) begin : g_fa
            mult_nmbit_fa u_fa (
                .a  (w_acc[j][k]),
                .b  (w_pp[j][k]),
                .ci (w_c[k-1]),
                .s  (w_acc[j+1][k]),
                .co (w_c[k])
            );
        end

        assign w_acc[j+1][c_W-1] = w_acc[j][c_W-1] ^ w_pp[j][c_W-1] ^ w_c[c_W-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_prod  <= w_acc[M];
            r_valid <= in_valid;
        end
    end

    assign Prod      = r_prod;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mult_nmbit.sv
// =============================================================================
// Module   : tb_mult_nmbit
// Brief    : Self-checking bench for mult_nmbit against a signed arithmetic model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mult_nmbit;
    localparam int N = 4;
    localparam int M = 5;
    localparam int W = N + M;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] A = '0;
    logic [M-1:0] B = '0;
    logic [W-1:0] Prod;
    logic         out_valid;

    int n_vec  = 0;
    int n_miss = 0;

    mult_nmbit #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Prod      (Prod),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_prod(input logic [N-1:0] a, input logic [M-1:0] b);
        logic signed [N-1:0] sa;
        logic signed [M-1:0] sb;
        int p;
        sa = a;
        sb = b;
        p  = int'(sa) * int'(sb);
        return W'(p);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive away from the edge, then sample 1 time unit after the capturing edge.
    task automatic apply(input string tag, input logic [N-1:0] a, input logic [M-1:0] b,
                         input logic v);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = v;
        @(posedge clk);
        #1;
        check({tag, "_prod"}, 32'(Prod), 32'(ref_prod(a, b)));
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        A = 4'b0011;
        B = 5'b00010;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_prod", 32'(Prod), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("p3x2", 4'b0011, 5'b00010, 1'b1);
        check("p3x2_const", 32'(Prod), 32'h006);
        apply("p5x5", 4'b0101, 5'b00101, 1'b1);
        check("p5x5_const", 32'(Prod), 32'h019);
        apply("m1x3", 4'b1111, 5'b00011, 1'b1);
        check("m1x3_const", 32'(Prod), 32'h1FD);
        apply("m6x1", 4'b1010, 5'b00001, 1'b1);
        check("m6x1_const", 32'(Prod), 32'h1FA);
        apply("m1x1", 4'b1111, 5'b00001, 1'b1);
        check("m1x1_const", 32'(Prod), 32'h1FF);
        apply("n1n1", 4'b1111, 5'b11111, 1'b1);
        check("n1n1_const", 32'(Prod), 32'h001);
        apply("n5n5", 4'b1011, 5'b11011, 1'b1);
        check("n5n5_const", 32'(Prod), 32'h019);
        apply("corner", 4'b1000, 5'b10000, 1'b1);
        check("corner_const", 32'(Prod), 32'h080);
        apply("zero", 4'b0000, 5'b11111, 1'b1);
        check("zero_const", 32'(Prod), 32'h000);
        apply("novalid", 4'b0101, 5'b00101, 1'b0);
        check("novalid_const", 32'(Prod), 32'h019);

        // Asynchronous reset in the middle of a cycle.
        apply("pre_rst", 4'b0011, 5'b00010, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_prod", 32'(Prod), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_prod", 32'(Prod), 32'h006);
        check("post_rst_valid", 32'(out_valid), 32'd1);

        for (int i = 0; i < (1 << W); i++) begin
            apply("sweep", N'(i >> M), M'(i), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 200; i++) begin
            apply("rand", N'($urandom), M'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mult_nmbit.md
Name: mult_nmbit

Overview:
- Parameterised signed (two's-complement) N×M-bit multiplier with a registered product.
- A Baugh-Wooley partial-product array built from full/half-adder cells forms the full-precision N+M-bit product combinationally.
- The product is captured in an output register every clock edge.
- Used as a reusable arithmetic leaf in datapaths needing exact signed products of unequal operand widths.

Parameters:
- N, 4, width of operand A in bits (≥2)
- M, 5, width of operand B in bits (≥2)

Ports:
- clk  input  1  rising-edge clock; the single clock of the block
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands on A/B are valid this cycle
- A  input  N  multiplicand, signed two's complement
- B  input  M  multiplier, signed two's complement
- Prod  output  N+M  registered signed product A×B
- out_valid  output  1  Prod holds the product of a valid operand pair

Behaviour:
- Reset: asynchronous assertion (rst_n=0) immediately clears Prod to 0 and out_valid to 0, independent of clk. Deassertion is synchronised externally.
- Arithmetic:
  - Prod = signed(A) × signed(B), exact, full N+M bits.
  - No overflow is possible; no truncation or saturation.
  - The range spans −2^(N−1)·(2^(M−1)−1) to 2^(N+M−2).
- Array structure:
  - Baugh-Wooley form: partial products a_i·b_j for i<N−1 and j<M−1.
  - Sign-row and sign-column terms are inverted: ~(a_{N−1}·b_j) and ~(a_i·b_{M−1}).
  - a_{N−1}·b_{M−1} is kept uninverted.
  - Correction constant: 1 added at bit N−1, at bit M−1, and at bit N+M−1 (for N=M this is 1 added at bits N and 2N−1).
  - Reduction uses a ripple-carry array of full/half adders generated from N and M.
  - A behavioural '*' operator is not permitted.
- Latency: 1 cycle. Operands present before rising edge k appear on Prod after edge k.
- Registers:
  - Prod updates every cycle regardless of in_valid.
  - out_valid <= in_valid each edge.
- No backpressure; a new operand pair is accepted every cycle (throughput 1/cycle).
- Combinational settling of the array must complete within one clock period. No pipelining inside the array.
- Reset mid-operation discards the in-flight product. The first post-reset edge loads the product of the current inputs, with out_valid = in_valid.
- Zero operand on either side gives Prod=0 for any value of the other operand.
- Most-negative × most-negative gives the positive result 2^(N+M−2), with MSB 0.

Test Plan:
- Defaults N=4, M=5. Hold each operand pair for ≥2 clocks and check Prod one edge after applying it, with in_valid=1.
- Reset: assert rst_n=0 asynchronously mid-cycle with A=0011, B=00010 applied → Prod=000000000 and out_valid=0 immediately. After release, the next edge gives Prod=000000110 and out_valid=1.
- Positive products:
  - A=0011, B=00010 (3×2) → Prod=000000110.
  - A=0101, B=00101 (5×5) → Prod=000011001.
- Mixed signs:
  - A=1111, B=00011 (−1×3) → Prod=111111101.
  - A=1010, B=00001 (−6×1) → Prod=111111010.
  - A=1111, B=00001 → Prod=111111111.
- Negative × negative:
  - A=1111, B=11111 (−1×−1) → Prod=000000001.
  - A=1011, B=11011 (−5×−5) → Prod=000011001.
  - Corner A=1000, B=10000 (−8×−16) → Prod=010000000.
- Zero and valid tracking:
  - A=0000, B=11111 → Prod=000000000.
  - Drop in_valid=0 → out_valid=0 one edge later while Prod still updates.
  - Exhaustive sweep of all 2^9 operand pairs compared against a signed reference model with no mismatches.
